mph_project_mux: RTL and testbench
==================================

// Module: mph_project_mux
// PURPOSE
// - Parametrised multi-project harness core: hosts NUM_PROJ user projects behind one Caravel user area.
// - Wishbone-programmable selection; exactly one project (or none) drives the GPIO pads at any time.
// - Safe switching: old project deactivated, pads tristated for GUARD_CYCLES, then new project enabled.
// - Replaces the single hard-wired project with one LA-driven active bit.
// PARAMETERS
// - NUM_PROJ      8             number of hosted projects (2..16)
// - IO_W          38            GPIO pads muxed per project (`MPRJ_IO_PADS)
// - GUARD_CYCLES  4             tristate-only cycles between deselect and select (>=1)
// - SEL_W         $clog2(NUM_PROJ)  project index width (derived, not overridden)
// PORTS
// - wb_clk_i        in   1                 sole clock
// - wb_rst_i        in   1                 reset, asynchronous, active-high
// - wbs_stb_i       in   1                 WB strobe (block already address-selected upstream)
// - wbs_cyc_i       in   1                 WB cycle
// - wbs_we_i        in   1                 WB write enable
// - wbs_sel_i       in   4                 WB byte lanes; byte 0 required for CTRL write to take effect
// - wbs_adr_i       in   32                WB address; only [3:2] decoded
// - wbs_dat_i       in   32                WB write data
// - wbs_ack_o       out  1                 WB ack
// - wbs_dat_o       out  32                WB read data
// - active_o        out  NUM_PROJ          one-hot project enable (all-zero allowed)
// - proj_io_out_i   in   NUM_PROJ*IO_W     per-project io_out, project p at [p*IO_W +: IO_W]
// - proj_io_oeb_i   in   NUM_PROJ*IO_W     per-project io_oeb, same packing
// - io_out          out  IO_W              pad output
// - io_oeb          out  IO_W              pad output-enable-bar (1 = tristate)
// BEHAVIOUR
// - Reset (async): state IDLE, CTRL=0, STATUS err=0, active_o=0, io_out=0, io_oeb=all-1, ack=0, dat_o=0.
// - Registers: 0x0 CTRL rw: [SEL_W-1:0] req_idx, [31] enable. 0x4 STATUS: [SEL_W-1:0] cur_idx (ro),
//   [9:8] state (ro), [12] busy (ro, =DRAIN or pending), [16] err (W1C). 0x8/0xC read 0, writes ignored.
// - WB: ack asserted exactly 1 cycle after stb&cyc seen with ack low; ack high for one cycle only;
//   back-to-back accesses therefore complete every 2 cycles. dat_o valid with ack, 0 otherwise.
// - CTRL write with req_idx >= NUM_PROJ and enable=1: CTRL unchanged, err set, no switch.
// - FSM: IDLE -> SEL when enable=1 written. SEL: active_o=onehot(req_idx), cur_idx<=req_idx -> ACTIVE next cycle.
//   ACTIVE: write with different idx or enable=0 -> DRAIN. Same idx & enable=1 rewritten: no effect.
//   DRAIN: active_o=0, io_oeb all-1, count GUARD_CYCLES; at end -> SEL if enable=1 else IDLE.
// - Writes during DRAIN update CTRL only (last write wins); DRAIN never restarts or shortens.
// - Pads: io_out/io_oeb registered, 1-cycle latency from selected project inputs in ACTIVE;
//   in IDLE/SEL/DRAIN io_oeb=all-1, io_out=0. First pad drive = 2 cycles after active_o rises.
// - active_o drops the same cycle pads go tristate (entry to DRAIN); never two bits set.
// - Reset mid-DRAIN or mid-ACTIVE: immediate return to reset values, no guard period.
// - NUM_PROJ not power of 2: unused indices treated as out-of-range (err).
// STRUCTURE
// - Shared package mph_pkg: state enum (IDLE, SEL, ACTIVE, DRAIN), register offsets, field bit positions.
// - Sub-module mph_wb_regs: WB ack/readback, CTRL/err storage, emits write strobe to FSM.
// - Top holds FSM, guard counter, one-hot decode and registered pad mux.
// TESTING
// - Reset, write CTRL=0x8000_0003 -> active_o=0x08 after 1 cycle, io_out=proj3 value 2 cycles later.
// - ACTIVE on 3, write CTRL=0x8000_0005 -> active_o=0, io_oeb=all-1 for 4 cycles, then active_o=0x20.
// - NUM_PROJ=8, write CTRL=0x8000_0009 -> err=1, active_o unchanged; write 0x1_0000 to 0x4 -> err=0.
// - During DRAIN write idx 1 then idx 6 -> after guard only bit 6 set; drain length still 4.
// - Write enable=0 while ACTIVE -> DRAIN then IDLE, io_oeb stays all-1, STATUS busy clears.
// - Assert wb_rst_i mid-DRAIN -> active_o=0, io_oeb=all-1, CTRL reads 0, next write starts clean.

Source files
------------

// File: rtl/mph_pkg.sv
// Shared definitions for the multi-project pad mux.
//   state_e      : switching FSM states, encoding is visible in STATUS[9:8]
//   Reg*         : register word offsets (wbs_adr_i[3:2])
//   *Bit / *Lsb  : register field positions
package mph_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSel    = 2'd1,
    StActive = 2'd2,
    StDrain  = 2'd3
  } state_e;

  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegStatus = 2'd1;

  localparam int unsigned CtrlEnBit    = 31;
  localparam int unsigned StatStateLsb = 8;
  localparam int unsigned StatBusyBit  = 12;
  localparam int unsigned StatErrBit   = 16;

endpackage

// File: rtl/mph_project_mux_if.sv
// Wishbone slave bus for the project mux register block.
//   master : drives stb/cyc/we/sel/adr/dat_i, receives ack/dat_o
//   slave  : the register block side
interface mph_project_mux_if;

  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

endinterface

// File: rtl/mph_wb_regs.sv
// Wishbone register block for the project mux.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   wb              : Wishbone slave bus
//   state_i         : current switching state (STATUS readback)
//   cur_idx_i       : currently/last selected project (STATUS readback)
//   busy_i          : switch in progress or pending (STATUS readback)
//   ctrl_idx_o      : requested project index
//   ctrl_en_o       : requested enable
// Each access is acknowledged one cycle after it is seen with ack low; ack
// lasts one cycle, so a held strobe completes every second cycle.
module mph_wb_regs
  import mph_pkg::*;
#(
  parameter int unsigned NUM_PROJ = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_PROJ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mph_project_mux_if.slave wb,
  input  state_e           state_i,
  input  logic [SEL_W-1:0] cur_idx_i,
  input  logic             busy_i,
  output logic [SEL_W-1:0] ctrl_idx_o,
  output logic             ctrl_en_o
);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             en_q, en_d;
  logic             err_q, err_d;

  logic             access;
  logic             wr;
  logic [1:0]       reg_sel;
  logic             idx_bad;
  logic [31:0]      rdata;

  assign access  = wb.wbs_stb_i & wb.wbs_cyc_i & ~ack_q;
  assign wr      = access & wb.wbs_we_i;
  assign reg_sel = wb.wbs_adr_i[3:2];
  // The whole low byte is range-checked so indices that alias into SEL_W bits
  // (and unused indices of a non-power-of-2 count) are rejected.
  assign idx_bad = 32'(wb.wbs_dat_i[7:0]) >= NUM_PROJ;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      RegCtrl: begin
        rdata[SEL_W-1:0] = idx_q;
        rdata[CtrlEnBit] = en_q;
      end
      RegStatus: begin
        rdata[SEL_W-1:0]          = cur_idx_i;
        rdata[StatStateLsb +: 2]  = state_i;
        rdata[StatBusyBit]        = busy_i;
        rdata[StatErrBit]         = err_q;
      end
      default: rdata = '0;
    endcase
  end

  always_comb begin
    ack_d = access;
    dat_d = access ? rdata : '0;
    idx_d = idx_q;
    en_d  = en_q;
    err_d = err_q;
    if (wr && reg_sel == RegCtrl && wb.wbs_sel_i[0]) begin
      if (wb.wbs_dat_i[CtrlEnBit] && idx_bad) begin
        err_d = 1'b1;
      end else begin
        idx_d = wb.wbs_dat_i[SEL_W-1:0];
        en_d  = wb.wbs_dat_i[CtrlEnBit];
      end
    end
    if (wr && reg_sel == RegStatus && wb.wbs_dat_i[StatErrBit]) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      idx_q <= '0;
      en_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      idx_q <= idx_d;
      en_q  <= en_d;
      err_q <= err_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_q;
  assign ctrl_idx_o   = idx_q;
  assign ctrl_en_o    = en_q;

  logic unused_bits;
  assign unused_bits = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0], wb.wbs_sel_i[3:1],
                         wb.wbs_dat_i[30:17], wb.wbs_dat_i[15:8]};

endmodule

// File: rtl/mph_project_mux.sv
// Multi-project harness core: selects at most one of NUM_PROJ projects onto
// the GPIO pads, with a tristate guard period whenever the selection changes.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   wb                 : Wishbone slave bus (CTRL / STATUS registers)
//   active_o           : one-hot project enable, all-zero when none active
//   proj_io_out_i      : per-project io_out, project p at [p*IO_W +: IO_W]
//   proj_io_oeb_i      : per-project io_oeb, same packing
//   io_out, io_oeb     : registered pad outputs (io_oeb 1 = tristate)
module mph_project_mux
  import mph_pkg::*;
#(
  parameter int unsigned NUM_PROJ     = 8,
  parameter int unsigned IO_W         = 38,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  mph_project_mux_if.slave         wb,
  output logic [NUM_PROJ-1:0]      active_o,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out_i,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_oeb_i,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb
);

  localparam int unsigned SEL_W = $clog2(NUM_PROJ);
  localparam int unsigned CntW  = $clog2(GUARD_CYCLES) + 1;

  state_e              state_q;
  logic [SEL_W-1:0]    cur_idx_q;
  logic [NUM_PROJ-1:0] active_q;
  logic [CntW-1:0]     cnt_q;
  logic [IO_W-1:0]     io_out_q;
  logic [IO_W-1:0]     io_oeb_q;

  logic [SEL_W-1:0]    ctrl_idx;
  logic                ctrl_en;
  logic                drain_req;
  logic                busy;
  logic [NUM_PROJ-1:0] req_onehot;
  logic [IO_W-1:0]     sel_out;
  logic [IO_W-1:0]     sel_oeb;

  mph_wb_regs #(
    .NUM_PROJ (NUM_PROJ),
    .SEL_W    (SEL_W)
  ) u_regs (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .wb         (wb),
    .state_i    (state_q),
    .cur_idx_i  (cur_idx_q),
    .busy_i     (busy),
    .ctrl_idx_o (ctrl_idx),
    .ctrl_en_o  (ctrl_en)
  );

  // Level-sensitive on CTRL: a rewrite of the active selection is a no-op,
  // and a change landing during SEL is picked up on the first ACTIVE cycle.
  assign drain_req  = ~ctrl_en | (ctrl_idx != cur_idx_q);
  assign req_onehot = {{(NUM_PROJ-1){1'b0}}, 1'b1} << ctrl_idx;

  assign busy = (state_q == StDrain) || (state_q == StSel) ||
                (state_q == StIdle && ctrl_en) || (state_q == StActive && drain_req);

  always_comb begin
    sel_out = '0;
    sel_oeb = '1;
    for (int p = 0; p < NUM_PROJ; p++) begin
      if (cur_idx_q == SEL_W'(p)) begin
        sel_out = proj_io_out_i[p*IO_W +: IO_W];
        sel_oeb = proj_io_oeb_i[p*IO_W +: IO_W];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= StIdle;
      cur_idx_q <= '0;
      active_q  <= '0;
      cnt_q     <= '0;
      io_out_q  <= '0;
      io_oeb_q  <= '1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_en) begin
            state_q   <= StSel;
            cur_idx_q <= ctrl_idx;
            active_q  <= req_onehot;
          end
        end
        StSel: state_q <= StActive;
        StActive: begin
          if (drain_req) begin
            state_q  <= StDrain;
            active_q <= '0;
            cnt_q    <= CntW'(GUARD_CYCLES - 1);
          end
        end
        StDrain: begin
          // Guard length is fixed at entry; CTRL writes only choose the exit.
          if (cnt_q == '0) begin
            if (ctrl_en) begin
              state_q   <= StSel;
              cur_idx_q <= ctrl_idx;
              active_q  <= req_onehot;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Pads follow the project only while it stays ACTIVE, so they tristate
      // on the same edge that active_o drops.
      if (state_q == StActive && !drain_req) begin
        io_out_q <= sel_out;
        io_oeb_q <= sel_oeb;
      end else begin
        io_out_q <= '0;
        io_oeb_q <= '1;
      end
    end
  end

  assign active_o = active_q;
  assign io_out   = io_out_q;
  assign io_oeb   = io_oeb_q;

endmodule

// File: tb/tb_mph_project_mux.sv
module tb_mph_project_mux;

  localparam int unsigned NP  = 8;
  localparam int unsigned IOW = 38;
  localparam int unsigned G   = 4;
  localparam int unsigned SW  = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NP-1:0]       active;
  logic [NP*IOW-1:0]   p_out, p_oeb;
  logic [IOW-1:0]      io_out, io_oeb;

  mph_project_mux_if wb_if ();

  mph_project_mux #(
    .NUM_PROJ     (NP),
    .IO_W         (IOW),
    .GUARD_CYCLES (G)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wb            (wb_if),
    .active_o      (active),
    .proj_io_out_i (p_out),
    .proj_io_oeb_i (p_oeb),
    .io_out        (io_out),
    .io_oeb        (io_oeb)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [NP-1:0]  act;
    logic [IOW-1:0] out;
    logic [IOW-1:0] oeb;
    logic           ack;
  } exp_t;

  exp_t        tl_q[$];
  logic [31:0] rd_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: selection timeline kept as timestamps.
  //   a project rises on edge r (active_o set), pads follow from edge r+2;
  //   a change seen on an edge >= r+2 drops it and starts a G-edge guard;
  //   at the guard's end the latest CTRL decides what rises next.
  // ---------------------------------------------------------------------
  int          cyc = 0;
  bit          m_en, m_err, m_on, m_drain, m_ack;
  logic [SW-1:0] m_ctrl_idx;
  int          m_pidx, m_rise, m_drain_end;

  always @(posedge clk) begin : model
    exp_t        e;
    logic [31:0] rdata;
    logic [31:0] d;
    logic [1:0]  r;
    int          st;
    bit          busy, acc;
    cyc++;
    if (rst) begin
      m_en = 0; m_err = 0; m_on = 0; m_drain = 0; m_ack = 0;
      m_ctrl_idx = '0; m_pidx = 0; m_rise = 0; m_drain_end = 0;
      e.act = '0; e.out = '0; e.oeb = '1; e.ack = 1'b0;
      tl_q.push_back(e);
    end else begin
      // Readback reflects the situation before this edge.
      if (m_drain) st = 3;
      else if (m_on) st = (cyc - 1 == m_rise) ? 1 : 2;
      else st = 0;
      busy = (st == 3) || (st == 1) || (st == 0 && m_en) ||
             (st == 2 && (!m_en || int'(m_ctrl_idx) != m_pidx));
      r = wb_if.wbs_adr_i[3:2];
      d = wb_if.wbs_dat_i;
      rdata = '0;
      if (r == 2'd0) begin
        rdata[SW-1:0] = m_ctrl_idx;
        rdata[31]     = m_en;
      end else if (r == 2'd1) begin
        rdata[SW-1:0] = m_pidx[SW-1:0];
        rdata[9:8]    = st[1:0];
        rdata[12]     = busy;
        rdata[16]     = m_err;
      end

      // Selection timeline uses CTRL as written before this edge.
      if (m_drain) begin
        if (cyc == m_drain_end) begin
          m_drain = 0;
          if (m_en) begin m_on = 1; m_pidx = int'(m_ctrl_idx); m_rise = cyc; end
        end
      end else if (m_on) begin
        if (cyc >= m_rise + 2 && (!m_en || int'(m_ctrl_idx) != m_pidx)) begin
          m_on = 0; m_drain = 1; m_drain_end = cyc + G;
        end
      end else if (m_en) begin
        m_on = 1; m_pidx = int'(m_ctrl_idx); m_rise = cyc;
      end

      e.act = m_on ? NP'(1) << m_pidx : '0;
      if (m_on && cyc >= m_rise + 2) begin
        e.out = p_out[m_pidx*IOW +: IOW];
        e.oeb = p_oeb[m_pidx*IOW +: IOW];
      end else begin
        e.out = '0;
        e.oeb = '1;
      end

      acc   = wb_if.wbs_stb_i && wb_if.wbs_cyc_i && !m_ack;
      m_ack = acc;
      e.ack = acc;
      if (acc) begin
        rd_q.push_back(rdata);
        if (wb_if.wbs_we_i && r == 2'd0 && wb_if.wbs_sel_i[0]) begin
          if (d[31] && d[7:0] >= 8'(NP)) m_err = 1;
          else begin m_ctrl_idx = d[SW-1:0]; m_en = d[31]; end
        end
        if (wb_if.wbs_we_i && r == 2'd1 && d[16]) m_err = 0;
      end
      tl_q.push_back(e);
    end
  end

  // Monitor: compares every cycle, pops read data whenever the DUT acks.
  initial begin : monitor
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (tl_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL timeline: got empty queue expected one entry at %0t", $time);
      end else begin
        e = tl_q.pop_front();
        check("active_o", 64'(active), 64'(e.act));
        check("io_out", 64'(io_out), 64'(e.out));
        check("io_oeb", 64'(io_oeb), 64'(e.oeb));
        check("ack", 64'(wb_if.wbs_ack_o), 64'(e.ack));
      end
      if (wb_if.wbs_ack_o) begin
        if (rd_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rdata: got ack with %h expected no ack", wb_if.wbs_dat_o);
        end else begin
          check("rdata", 64'(wb_if.wbs_dat_o), 64'(rd_q.pop_front()));
        end
      end else begin
        check("dat_idle", 64'(wb_if.wbs_dat_o), 64'd0);
      end
    end
  end

  // Project outputs change every cycle so pad latency is visible.
  initial begin : proj_drv
    forever begin
      for (int p = 0; p < NP; p++) begin
        p_out[p*IOW +: IOW] = IOW'({$urandom(), $urandom()});
        p_oeb[p*IOW +: IOW] = IOW'({$urandom(), $urandom()});
      end
      @(negedge clk);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge where ack is seen.
  task automatic wb_xfer(input bit we, input logic [1:0] r, input logic [31:0] d,
                         input logic [3:0] s);
    logic [31:0] a;
    bit          seen;
    a = $urandom();
    wb_if.wbs_adr_i = {a[31:4], r, a[1:0]};
    wb_if.wbs_dat_i = d;
    wb_if.wbs_we_i  = we;
    wb_if.wbs_sel_i = s;
    wb_if.wbs_stb_i = 1'b1;
    wb_if.wbs_cyc_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = wb_if.wbs_ack_o;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
    end
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int          k;
    logic [31:0] d;
    logic [3:0]  s;
    rst = 1'b1;
    wb_if.wbs_stb_i = 1'b0;
    wb_if.wbs_cyc_i = 1'b0;
    wb_if.wbs_we_i  = 1'b0;
    wb_if.wbs_sel_i = 4'h0;
    wb_if.wbs_adr_i = '0;
    wb_if.wbs_dat_i = '0;
    idle(3);
    rst = 1'b0;
    idle(1);

    wb_xfer(0, 2'd1, 32'h0, 4'hF);               // STATUS after reset
    wb_xfer(0, 2'd0, 32'h0, 4'hF);               // CTRL after reset
    wb_xfer(1, 2'd0, 32'h8000_0003, 4'hF);       // select project 3
    idle(6);
    wb_xfer(1, 2'd0, 32'h8000_0003, 4'hF);       // same selection rewritten
    idle(3);
    wb_xfer(1, 2'd0, 32'h8000_0005, 4'hF);       // switch to 5 through guard
    idle(10);
    wb_xfer(1, 2'd0, 32'h8000_0009, 4'hF);       // out of range
    wb_xfer(0, 2'd1, 32'h0, 4'hF);
    wb_xfer(1, 2'd1, 32'h0001_0000, 4'hF);       // clear err
    wb_xfer(0, 2'd1, 32'h0, 4'hF);
    wb_xfer(1, 2'd0, 32'h8000_0002, 4'hF);       // start a drain...
    wb_xfer(1, 2'd0, 32'h8000_0001, 4'hF);       // ...rewritten twice inside it
    wb_xfer(1, 2'd0, 32'h8000_0006, 4'hF);
    idle(10);
    wb_xfer(1, 2'd0, 32'h0000_0006, 4'hF);       // disable
    wb_xfer(0, 2'd1, 32'h0, 4'hF);
    idle(8);
    wb_xfer(0, 2'd1, 32'h0, 4'hF);
    wb_xfer(1, 2'd0, 32'h8000_0004, 4'hF);
    idle(6);
    wb_xfer(1, 2'd0, 32'h8000_0002, 4'hF);       // reset lands mid-drain
    idle(1);
    do_reset();
    wb_xfer(0, 2'd0, 32'h0, 4'hF);
    wb_xfer(1, 2'd0, 32'h8000_0001, 4'hF);
    idle(6);
    wb_xfer(0, 2'd2, 32'h0, 4'hF);
    wb_xfer(1, 2'd3, 32'hFFFF_FFFF, 4'hF);

    for (int t = 0; t < 120; t++) begin
      k = $urandom_range(0, 9);
      d = $urandom();
      s = 4'hF;
      if ($urandom_range(0, 5) == 0) s = 4'($urandom());
      if (k < 4) begin
        d[7:0] = ($urandom_range(0, 7) == 0) ? 8'($urandom()) : 8'($urandom_range(0, NP + 1));
        d[31]  = ($urandom_range(0, 3) != 0);
        wb_xfer(1, 2'd0, d, s);
      end else if (k < 6) begin
        wb_xfer(0, 2'($urandom_range(0, 3)), d, s);
      end else if (k < 7) begin
        wb_xfer(1, 2'd1, d, s);
      end else if (k < 8) begin
        wb_xfer(1, 2'($urandom_range(2, 3)), d, s);
      end else if (t == 60) begin
        do_reset();
      end
      idle($urandom_range(0, 7));
    end

    idle(12);
    check("rd_q_left", 64'(rd_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
